// File: rtl/regseq_pkg.sv
// Shared opcodes, shift codes, FSM encodings and command bundle
// for the register-file operation sequencer.
package regseq_pkg;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ_A = 3'd1;
  localparam logic [2:0] S_READ_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    logic [1:0] shift;
  } cmd_t;

  function automatic logic is_rsvd(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // First state entered after accepting a command.
  function automatic logic [2:0] first_state(
    input logic [2:0] op
  );
    logic [2:0] s;
    s = S_DONE;
    unique case (1'b1)
      (op == OP_MOVI):                 s = S_WRITE;
      (op == OP_MOV), (op == OP_MVN):  s = S_READ_B;
      (op == OP_ADD), (op == OP_AND),
      (op == OP_CMP):                  s = S_READ_A;
      default:                         s = S_DONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Command handshake bundle for the register-file sequencer.
// master issues commands, slave (the sequencer) accepts them.
interface regfile_op_sequencer_if #(
  parameter int IMM_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_rd;
  logic [2:0]       cmd_rn;
  logic [2:0]       cmd_rm;
  logic [1:0]       cmd_shift;
  logic [IMM_W-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rd,
    output cmd_rn, cmd_rm, cmd_shift,
    output cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd,
    input  cmd_rn, cmd_rm, cmd_shift,
    input  cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/regseq_alu.sv
// Combinational shifter, ALU and status flag generation
// for the register-file sequencer.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   op_i,
  input  logic [1:0]   shift_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         z_o,
  output logic         n_o,
  output logic         v_o
);

  logic [W-1:0] sb;
  logic [W-1:0] sum;
  logic [W-1:0] dif;

  always_comb begin
    sb = b_i;
    unique case (shift_i)
      SH_NONE: sb = b_i;
      SH_LSL:  sb = {b_i[W-2:0], 1'b0};
      SH_LSR:  sb = {1'b0, b_i[W-1:1]};
      SH_ASR:  sb = {b_i[W-1], b_i[W-1:1]};
      default: sb = b_i;
    endcase
  end

  assign sum = a_i + sb;
  assign dif = a_i - sb;

  always_comb begin
    result_o = '0;
    v_o      = 1'b0;
    unique case (1'b1)
      (op_i == OP_MOV): result_o = sb;
      (op_i == OP_AND): result_o = a_i & sb;
      (op_i == OP_MVN): result_o = ~sb;
      (op_i == OP_ADD): begin
        result_o = sum;
        v_o = ~(a_i[W-1] ^ sb[W-1])
            & (sum[W-1] ^ a_i[W-1]);
      end
      (op_i == OP_CMP): begin
        result_o = dif;
        v_o = (a_i[W-1] ^ sb[W-1])
            & (dif[W-1] ^ a_i[W-1]);
      end
      default: begin
        result_o = '0;
        v_o      = 1'b0;
      end
    endcase
  end

  assign z_o = (result_o == '0);
  assign n_o = result_o[W-1];

endmodule

// File: rtl/regfile_op_sequencer.sv
// Fetch/execute/writeback sequencer for the 8xW register file.
// Optional status flags: define REGSEQ_FLAGS_EN.
module regfile_op_sequencer
  import regseq_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_op_sequencer_if.slave cmd,
  output logic [2:0]   readnum,
  input  logic [W-1:0] rf_data,
  output logic [2:0]   writenum,
  output logic         write,
  output logic [W-1:0] data_in,
  output logic         done,
  output logic         err,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_v
);

  logic [2:0]   state_q, state_d;
  cmd_t         cmd_q;
  logic [W-1:0] a_q, b_q, c_q;
  logic         accept;
  logic [W-1:0] imm_ext;
  logic [W-1:0] alu_res;
  logic         alu_z, alu_n, alu_v;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign accept  = cmd.cmd_valid & cmd.cmd_ready;
  assign imm_ext = {{(W-IMM_W){cmd.cmd_imm[IMM_W-1]}},
                    cmd.cmd_imm};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept) state_d = first_state(cmd.cmd_op);
      S_READ_A: state_d = S_READ_B;
      S_READ_B: state_d = S_EXEC;
      S_EXEC:
        state_d = (cmd_q.op == OP_CMP) ? S_DONE : S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q.op    <= cmd.cmd_op;
        cmd_q.rd    <= cmd.cmd_rd;
        cmd_q.rn    <= cmd.cmd_rn;
        cmd_q.rm    <= cmd.cmd_rm;
        cmd_q.shift <= cmd.cmd_shift;
        if (cmd.cmd_op == OP_MOVI) c_q <= imm_ext;
      end
      if (state_q == S_READ_A) a_q <= rf_data;
      if (state_q == S_READ_B) b_q <= rf_data;
      // CMP only produces flags; C keeps the last result.
      if (state_q == S_EXEC && cmd_q.op != OP_CMP)
        c_q <= alu_res;
    end
  end

  regseq_alu #(.W(W)) u_alu (
    .op_i     (cmd_q.op),
    .shift_i  (cmd_q.shift),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res),
    .z_o      (alu_z),
    .n_o      (alu_n),
    .v_o      (alu_v)
  );

  assign readnum  = (state_q == S_READ_A) ? cmd_q.rn :
                    (state_q == S_READ_B) ? cmd_q.rm :
                    3'd0;
  assign writenum = cmd_q.rd;
  assign data_in  = c_q;
  assign write    = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err      = done & is_rsvd(cmd_q.op);

`ifdef REGSEQ_FLAGS_EN
  logic z_q, n_q, v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      z_q <= alu_z;
      n_q <= alu_n;
      v_q <= alu_v;
    end
  end

  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
`else
  logic unused_flags;
  assign unused_flags = ^{alu_z, alu_n, alu_v};
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer with a
// behavioural 8x16 register file attached.
module tb_regfile_op_sequencer;
  import regseq_pkg::*;

`ifdef REGSEQ_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_op_sequencer_if #(.IMM_W(8)) cif();

  logic [2:0]  readnum, writenum;
  logic [15:0] rf_data, data_in;
  logic write, done, err;
  logic flag_z, flag_n, flag_v;

  regfile_op_sequencer #(.W(16), .IMM_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cif),
    .readnum  (readnum),
    .rf_data  (rf_data),
    .writenum (writenum),
    .write    (write),
    .data_in  (data_in),
    .done     (done),
    .err      (err),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_v   (flag_v)
  );

  logic [15:0] rf [8];
  bit ld = 1'b0;
  assign rf_data = rf[readnum];

  always @(posedge clk) begin
    if (!ld) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      rf[5] <= 16'h7FFF;
      rf[7] <= 16'h8001;
      ld <= 1'b1;
    end else if (write) begin
      rf[writenum] <= data_in;
    end
  end

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic err;
    int   lat;
    logic z, n, v;
  } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [2:0] rd,
                        input logic [15:0] d);
    wr_t w;
    w.rd = rd;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic exp_dn(input logic e, input int lat,
                        input logic z, input logic n,
                        input logic v);
    dn_t d;
    d.err = e;
    d.lat = lat;
    d.z = z & FL;
    d.n = n & FL;
    d.v = v & FL;
    dn_q.push_back(d);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cyc = 0;
  int acc_prev = 0;
  int n_acc = 0;

  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    if (rst_n) begin
      if (cif.cmd_valid && cif.cmd_ready) begin
        acc_prev = acc_cyc;
        acc_cyc = cyc;
        n_acc++;
      end
      if (write) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got wn=%0d want none",
                   writenum);
        end else begin
          w = wr_q.pop_front();
          chk("writenum", 32'(writenum), 32'(w.rd));
          chk("data_in", 32'(data_in), 32'(w.data));
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got 1 want 0");
        end else begin
          d = dn_q.pop_front();
          chk("err", 32'(err), 32'(d.err));
          chk("latency", 32'(cyc - acc_cyc), 32'(d.lat));
          chk("flags", {29'd0, flag_z, flag_n, flag_v},
              {29'd0, d.z, d.n, d.v});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cif.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(cif.cmd_ready), 32'd1);
  endtask

  task automatic set_cmd(input logic [2:0] op,
                         input logic [2:0] rd,
                         input logic [2:0] rn,
                         input logic [2:0] rm,
                         input logic [1:0] sh,
                         input logic [7:0] imm);
    cif.cmd_op = op;
    cif.cmd_rd = rd;
    cif.cmd_rn = rn;
    cif.cmd_rm = rm;
    cif.cmd_shift = sh;
    cif.cmd_imm = imm;
  endtask

  // Returns one step after the accepting edge.
  task automatic start(input logic [2:0] op,
                       input logic [2:0] rd,
                       input logic [2:0] rn,
                       input logic [2:0] rm,
                       input logic [1:0] sh,
                       input logic [7:0] imm);
    wait_idle();
    set_cmd(op, rd, rn, rm, sh, imm);
    cif.cmd_valid = 1'b1;
    tick();
    cif.cmd_valid = 1'b0;
    set_cmd(3'd7, 3'd7, 3'd7, 3'd7, 2'd3, 8'hAA);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin : drv
    int n;
    int base;
    cif.cmd_valid = 1'b0;
    set_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_ready", 32'(cif.cmd_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_readnum", 32'(readnum), 32'd0);
    chk("rst_writenum", 32'(writenum), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);

    exp_wr(3'd3, 16'hFFF6);
    exp_dn(1'b0, 2, 1'b0, 1'b0, 1'b0);
    start(OP_MOVI, 3'd3, 3'd0, 3'd0, SH_NONE, 8'hF6);

    exp_wr(3'd1, 16'hFFF6);
    exp_dn(1'b0, 4, 1'b0, 1'b1, 1'b0);
    start(OP_MOV, 3'd1, 3'd0, 3'd3, SH_NONE, 8'h00);

    exp_wr(3'd1, 16'h0005);
    exp_dn(1'b0, 2, 1'b0, 1'b1, 1'b0);
    start(OP_MOVI, 3'd1, 3'd0, 3'd0, SH_NONE, 8'h05);

    exp_wr(3'd2, 16'h0003);
    exp_dn(1'b0, 2, 1'b0, 1'b1, 1'b0);
    start(OP_MOVI, 3'd2, 3'd0, 3'd0, SH_NONE, 8'h03);

    exp_wr(3'd4, 16'h000B);
    exp_dn(1'b0, 5, 1'b0, 1'b0, 1'b0);
    start(OP_ADD, 3'd4, 3'd1, 3'd2, SH_LSL, 8'h00);
    chk("readnum_a", 32'(readnum), 32'd1);
    tick();
    chk("readnum_b", 32'(readnum), 32'd2);

    exp_dn(1'b0, 4, 1'b1, 1'b0, 1'b0);
    start(OP_CMP, 3'd6, 3'd5, 3'd5, SH_NONE, 8'h00);

    exp_wr(3'd6, 16'hFFFE);
    exp_dn(1'b0, 5, 1'b0, 1'b1, 1'b1);
    start(OP_ADD, 3'd6, 3'd5, 3'd5, SH_NONE, 8'h00);

    // MVN with valid held high: second accept right after DONE.
    exp_wr(3'd0, 16'h3FFF);
    exp_dn(1'b0, 4, 1'b0, 1'b0, 1'b0);
    exp_wr(3'd0, 16'h3FFF);
    exp_dn(1'b0, 4, 1'b0, 1'b0, 1'b0);
    wait_idle();
    base = n_acc;
    set_cmd(OP_MVN, 3'd0, 3'd0, 3'd7, SH_ASR, 8'h00);
    cif.cmd_valid = 1'b1;
    n = 0;
    while (n_acc < base + 2 && n < 50) begin
      tick();
      n++;
    end
    cif.cmd_valid = 1'b0;
    wait_idle();
    chk("reaccept_count", 32'(n_acc - base), 32'd2);
    chk("reaccept_gap", 32'(acc_cyc - acc_prev), 32'd5);

    exp_dn(1'b1, 1, 1'b0, 1'b0, 1'b0);
    start(3'b110, 3'd0, 3'd1, 3'd2, SH_NONE, 8'h00);

    exp_wr(3'd1, 16'h3FFF);
    exp_dn(1'b0, 4, 1'b0, 1'b0, 1'b0);
    start(OP_MOV, 3'd1, 3'd0, 3'd0, SH_NONE, 8'h00);

    // Abort an ADD into R6 during EXEC.
    start(OP_ADD, 3'd6, 3'd1, 3'd1, SH_NONE, 8'h00);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_write", 32'(write), 32'd0);
    chk("abort_ready", 32'(cif.cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    exp_wr(3'd2, 16'hFFFE);
    exp_dn(1'b0, 4, 1'b0, 1'b1, 1'b0);
    start(OP_MOV, 3'd2, 3'd0, 3'd6, SH_NONE, 8'h00);

    wait_idle();
    repeat (3) tick();
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("dn_q_empty", 32'(dn_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multicycle operand-fetch / execute / writeback controller for the 8x16 register file.
- Upstream of the register file: drives its `readnum`, `writenum`, `write` and `data_in`. Downstream of it: consumes its `data_out`, which is combinational from `readnum`.
- Accepts one register-to-register command per valid/ready handshake and performs MOV-imm, MOV, ADD, CMP, AND or MVN with an optional 1-bit shift.

Parameters:
- W, 16: datapath and register width.
- IMM_W, 8: immediate width; sign-extended to W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- cmd_op  in  3  opcode: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 reserved.
- cmd_rd  in  3  destination register.
- cmd_rn  in  3  operand A register.
- cmd_rm  in  3  operand B register.
- cmd_shift  in  2  shift on B: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- cmd_imm  in  IMM_W  immediate, used by MOVI.
- readnum  out  3  register file read select.
- rf_data  in  W  register file `data_out`.
- writenum  out  3  register file write select.
- write  out  1  register file write enable.
- data_in  out  W  register file write data.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with `done` for a reserved opcode.
- flag_z, flag_n, flag_v  out  1 each  status flags (optional feature).

Behaviour:
- Clock and reset (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state IDLE, so `cmd_ready` = 1.
  - `write`, `done`, `err` = 0.
  - `readnum`, `writenum` = 0.
  - `data_in` = 0.
  - A, B, C registers = 0.
  - flags = 0.
- Accept: `cmd_valid` & `cmd_ready` on a rising edge latches op, rd, rn, rm, shift and imm. Fields are not sampled again for the rest of the command.
- States: IDLE, READ_A, READ_B, EXEC, WRITE, DONE.
- Transitions after accept:
  - MOVI: WRITE; C = sext(imm) is loaded at accept.
  - MOV, MVN: READ_B, EXEC, WRITE.
  - ADD, AND: READ_A, READ_B, EXEC, WRITE.
  - CMP: READ_A, READ_B, EXEC; no WRITE.
  - Reserved: DONE directly; `err` = 1.
  - Every path then goes DONE, then IDLE.
- Latency from accept edge to `done` cycle: MOVI 2, MOV/MVN 4, ADD/AND 5, CMP 4, reserved 1.
- Read states:
  - READ_A: `readnum` = rn; `rf_data` latched into A at the end of the cycle.
  - READ_B: `readnum` = rm; `rf_data` latched into B.
  - Otherwise `readnum` = 0.
- EXEC: C <= result; flags update when enabled. Results:
  - MOV = sh(B).
  - ADD = A + sh(B), mod 2^W.
  - AND = A & sh(B).
  - MVN = ~sh(B).
  - CMP computes A - sh(B); C is unchanged.
- WRITE:
  - `write` = 1 for exactly one cycle.
  - `writenum` = latched rd; `data_in` = C.
  - The register file captures on the edge ending WRITE.
  - `write` is 0 in every other state.
- `writenum` holds the latched rd and `data_in` holds C between commands.
- `cmd_valid` asserted outside IDLE is ignored; the command is not queued.
- Back-to-back: a new command is accepted in the IDLE cycle after DONE. Reading a register written by the previous command returns the new value.
- rd equal to rn or rm is legal: operands are latched before WRITE.
- Reset mid-command:
  - immediate return to IDLE;
  - `write` drops asynchronously;
  - no partial write occurs;
  - `done` is not asserted.

Optional Feature:
- Macro: `REGSEQ_FLAGS_EN`.
- Defined: flags update in EXEC of ADD, CMP, AND, MVN, MOV. MOVI leaves them unchanged.
  - Z = result == 0.
  - N = result[W-1].
  - V = signed overflow for ADD/CMP; V = 0 for the other ops.
- Not defined: `flag_z`, `flag_n`, `flag_v` are tied 0, no flag registers exist, and CMP becomes a timing-only no-op (still 4-cycle latency, `done` pulse, no write).

Decomposition:
- Package `regseq_pkg` holds:
  - opcode constants OP_MOVI … OP_MVN;
  - shift codes SH_NONE/LSL/LSR/ASR;
  - state encodings.
- One combinational sub-module `regseq_alu` (shifter plus ALU plus flag generation). Inputs: op, shift, A, B. Outputs: result, z, n, v.
- The top level keeps the FSM, command latch and operand registers.

Test Plan:
- MOVI rd=3, imm=8'hF6 -> WRITE 1 cycle after accept; writenum=3; data_in=16'hFFF6; `done` in the next cycle; R3 reads FFF6.
- R1=0x0005, R2=0x0003; ADD rd=4, rn=1, rm=2, shift=LSL1 -> `readnum` 1 then 2; data_in=0x000B; `done` at accept+5.
- R5=0x7FFF; CMP rn=5, rm=5 -> `write` never asserted; with `REGSEQ_FLAGS_EN` Z=1, N=0, V=0. ADD R5+R5 into R6 -> 0xFFFE, N=1, V=1.
- MVN rd=0, rm=7 (R7=0x8001), shift=ASR1 -> data_in=0x3FFF; `cmd_valid` held high throughout is accepted again only after DONE.
- Reserved op 110 -> `done` and `err` pulse 1 cycle after accept; no write; registers unchanged.
- `rst_n` low during EXEC of ADD -> `write` stays 0; destination keeps its old value; `cmd_ready`=1 after release.
